// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT sequencer: default sizes, FSM encoding
// and the stage-counter width helper.
package fft_pkg;

    localparam int L   = 4;
    localparam int P   = 2 ** L;
    localparam int LAT = 1 + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    function automatic int sw_width(input int log2_pts);
        return ($clog2(log2_pts) < 1) ? 1 : $clog2(log2_pts);
    endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Radix-2 DIT butterfly address generator: maps (stage, butterfly index) to the
// two in-place data addresses and the twiddle ROM index.
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2_PTS = L,
    parameter int SW       = sw_width(LOG2_PTS)
) (
    input  logic [SW-1:0]       s,
    input  logic [LOG2_PTS-2:0] b,
    output logic [LOG2_PTS-1:0] addr0,
    output logic [LOG2_PTS-1:0] addr1,
    output logic [LOG2_PTS-2:0] tw_addr
);

    logic [LOG2_PTS-1:0] b_ext;
    logic [LOG2_PTS-1:0] span;
    logic [LOG2_PTS-1:0] pos;
    logic [LOG2_PTS-1:0] grp;

    always_comb begin
        b_ext   = {1'b0, b};
        span    = LOG2_PTS'(1) << s;
        pos     = b_ext & (span - 1'b1);
        grp     = b_ext >> s;
        // Shift in two steps so s+1 never overflows the SW-bit stage index.
        addr0   = ((grp << s) << 1) | pos;
        addr1   = addr0 | span;
        tw_addr = pos[LOG2_PTS-2:0] << (SW'(LOG2_PTS - 1) - s);
    end

endmodule

// File: rtl/fft_r2_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT: one butterfly issue per cycle, a
// LAT-cycle drain between stages, and a LAT-deep write-back address delay line.
module fft_r2_seq_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2_PTS = L,
    parameter int RD_LAT   = 1,
    parameter int BF_LAT   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [sw_width(LOG2_PTS)-1:0] stage,
    output logic                          rd_en,
    output logic [LOG2_PTS-1:0]           rd_addr0,
    output logic [LOG2_PTS-1:0]           rd_addr1,
    output logic [LOG2_PTS-2:0]           tw_addr,
    output logic                          wr_en,
    output logic [LOG2_PTS-1:0]           wr_addr0,
    output logic [LOG2_PTS-1:0]           wr_addr1
);

    localparam int SW   = sw_width(LOG2_PTS);
    localparam int BW   = LOG2_PTS - 1;
    localparam int NLAT = RD_LAT + BF_LAT;
    localparam int DW   = (NLAT > 1) ? $clog2(NLAT) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(LOG2_PTS - 1);
    localparam logic [BW-1:0] B_LAST = {BW{1'b1}};
    localparam logic [DW-1:0] D_LAST = DW'(NLAT - 1);

    typedef struct packed {
        logic                en;
        logic [LOG2_PTS-1:0] a0;
        logic [LOG2_PTS-1:0] a1;
    } wb_t;

    fsm_state_t    state, state_n;
    logic [SW-1:0] s_cnt, s_n;
    logic [BW-1:0] b_cnt, b_n;
    logic [DW-1:0] d_cnt, d_n;

    logic [LOG2_PTS-1:0] ag_addr0, ag_addr1;
    logic [LOG2_PTS-2:0] ag_tw;
    logic                run_n;

    wb_t dly [NLAT];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            s_cnt <= '0;
            b_cnt <= '0;
            d_cnt <= '0;
        end else begin
            state <= state_n;
            s_cnt <= s_n;
            b_cnt <= b_n;
            d_cnt <= d_n;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_n = state;
        s_n     = s_cnt;
        b_n     = b_cnt;
        d_n     = d_cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    s_n     = '0;
                    b_n     = '0;
                end
            end
            ST_RUN: begin
                if (b_cnt == B_LAST) begin
                    state_n = ST_DRAIN;
                    d_n     = '0;
                end else begin
                    b_n = b_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (d_cnt == D_LAST) begin
                    if (s_cnt == S_LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                        s_n     = s_cnt + 1'b1;
                        b_n     = '0;
                    end
                end else begin
                    d_n = d_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                s_n     = '0;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign run_n = (state_n == ST_RUN);

    // Addresses come from the next (s, b) so the registered rd_* line up with the RUN cycle.
    fft_bf_addr_gen #(
        .LOG2_PTS (LOG2_PTS),
        .SW       (SW)
    ) u_addr_gen (
        .s       (s_n),
        .b       (b_n),
        .addr0   (ag_addr0),
        .addr1   (ag_addr1),
        .tw_addr (ag_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            stage    <= '0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_addr  <= '0;
        end else begin
            busy     <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
            done     <= (state_n == ST_DONE);
            stage    <= ((state_n == ST_RUN) || (state_n == ST_DRAIN)) ? s_n : '0;
            rd_en    <= run_n;
            rd_addr0 <= run_n ? ag_addr0 : '0;
            rd_addr1 <= run_n ? ag_addr1 : '0;
            tw_addr  <= run_n ? ag_tw : '0;
        end
    end

    // NOTE: the delay line is reset so an abandoned transform leaves no stray write strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NLAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= '{en: rd_en, a0: rd_addr0, a1: rd_addr1};
            for (int i = 1; i < NLAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign wr_en    = dly[NLAT-1].en;
    assign wr_addr0 = dly[NLAT-1].a0;
    assign wr_addr1 = dly[NLAT-1].a1;

endmodule

// File: tb/tb_fft_r2_seq_ctrl.sv
// Directed bench for fft_r2_seq_ctrl at default parameters (16 points, LAT = 3).
module tb_fft_r2_seq_ctrl;

    localparam int NCAP = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [1:0] stage;
    logic [3:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [2:0] tw_addr;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] stage;
        logic       rd_en;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [2:0] tw;
        logic       wr_en;
        logic [3:0] w0;
        logic [3:0] w1;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    obs_t cap [NCAP];
    vec_t vecs [17];
    int   checks = 0;
    int   errors = 0;

    fft_r2_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .tw_addr  (tw_addr),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.busy  = busy;
        o.done  = done;
        o.stage = stage;
        o.rd_en = rd_en;
        o.a0    = rd_addr0;
        o.a1    = rd_addr1;
        o.tw    = tw_addr;
        o.wr_en = wr_en;
        o.w0    = wr_addr0;
        o.w1    = wr_addr1;
        return o;
    endfunction

    function automatic vec_t mkv(input int c, input bit bz, input bit dn, input int stg,
                                 input bit rd, input int a0, input int a1, input int tw,
                                 input bit wr, input int w0, input int w1);
        vec_t v;
        v.cyc       = c;
        v.exp.busy  = bz;
        v.exp.done  = dn;
        v.exp.stage = 2'(stg);
        v.exp.rd_en = rd;
        v.exp.a0    = 4'(a0);
        v.exp.a1    = 4'(a1);
        v.exp.tw    = 3'(tw);
        v.exp.wr_en = wr;
        v.exp.w0    = 4'(w0);
        v.exp.w1    = 4'(w1);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle c is the interval after clock edge c-1; start is sampled at edge 0.
    task automatic run_capture(input bit hold_start);
        for (int c = 0; c < NCAP; c++) begin
            @(negedge clk);
            start  = (c == 0) ? 1'b1 : hold_start;
            cap[c] = observe();
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag);
        int n_rd, n_wr, n_done, done_cyc, busy_bad, dly_bad;
        int seen [4][16];
        int first_rd [4];
        int last_wr;
        n_rd = 0; n_wr = 0; n_done = 0; done_cyc = -1; busy_bad = 0; dly_bad = 0;
        for (int s = 0; s < 4; s++) begin
            first_rd[s] = -1;
            for (int a = 0; a < 16; a++) seen[s][a] = 0;
        end

        foreach (vecs[i])
            check($sformatf("%s cyc%0d", tag, vecs[i].cyc), 32'(cap[vecs[i].cyc]), 32'(vecs[i].exp));

        for (int c = 0; c < NCAP; c++) begin
            if (cap[c].rd_en) begin
                n_rd++;
                seen[cap[c].stage][cap[c].a0]++;
                seen[cap[c].stage][cap[c].a1]++;
                if (first_rd[cap[c].stage] < 0) first_rd[cap[c].stage] = c;
            end
            if (cap[c].wr_en) n_wr++;
            if (cap[c].done) begin
                n_done++;
                done_cyc = c;
            end
            if (cap[c].busy !== (c >= 1 && c <= 44)) busy_bad++;
            if (c >= 3 && {cap[c].wr_en, cap[c].w0, cap[c].w1} !==
                          {cap[c-3].rd_en, cap[c-3].a0, cap[c-3].a1}) dly_bad++;
        end
        check({tag, " rd_en pulses"}, n_rd, 32);
        check({tag, " wr_en pulses"}, n_wr, 32);
        check({tag, " done pulses"}, n_done, 1);
        check({tag, " done cycle"}, done_cyc, 45);
        check({tag, " busy window errs"}, busy_bad, 0);
        check({tag, " wr vs rd-3 errs"}, dly_bad, 0);

        for (int s = 0; s < 4; s++) begin
            int bad;
            bad = 0;
            for (int a = 0; a < 16; a++) if (seen[s][a] != 1) bad++;
            check($sformatf("%s stage%0d coverage errs", tag, s), bad, 0);
            check($sformatf("%s stage%0d first rd cycle", tag, s), first_rd[s], 1 + 11 * s);
            if (s > 0) begin
                last_wr = -1;
                for (int c = 0; c < NCAP; c++)
                    if (cap[c].wr_en && c < first_rd[s]) last_wr = c;
                check($sformatf("%s stage%0d write-to-read gap", tag, s), first_rd[s] - last_wr, 1);
            end
        end
    endtask

    initial begin
        vecs[0]  = mkv( 0, 0, 0, 0, 0,  0,  0, 0, 0,  0,  0);
        vecs[1]  = mkv( 1, 1, 0, 0, 1,  0,  1, 0, 0,  0,  0);
        vecs[2]  = mkv( 4, 1, 0, 0, 1,  6,  7, 0, 1,  0,  1);
        vecs[3]  = mkv( 9, 1, 0, 0, 0,  0,  0, 0, 1, 10, 11);
        vecs[4]  = mkv(11, 1, 0, 0, 0,  0,  0, 0, 1, 14, 15);
        vecs[5]  = mkv(12, 1, 0, 1, 1,  0,  2, 0, 0,  0,  0);
        vecs[6]  = mkv(13, 1, 0, 1, 1,  1,  3, 4, 0,  0,  0);
        vecs[7]  = mkv(20, 1, 0, 1, 0,  0,  0, 0, 1,  9, 11);
        vecs[8]  = mkv(22, 1, 0, 1, 0,  0,  0, 0, 1, 13, 15);
        vecs[9]  = mkv(23, 1, 0, 2, 1,  0,  4, 0, 0,  0,  0);
        vecs[10] = mkv(28, 1, 0, 2, 1,  9, 13, 2, 1,  2,  6);
        vecs[11] = mkv(29, 1, 0, 2, 1, 10, 14, 4, 1,  3,  7);
        vecs[12] = mkv(37, 1, 0, 3, 1,  3, 11, 3, 1,  0,  8);
        vecs[13] = mkv(39, 1, 0, 3, 1,  5, 13, 5, 1,  2, 10);
        vecs[14] = mkv(44, 1, 0, 3, 0,  0,  0, 0, 1,  7, 15);
        vecs[15] = mkv(45, 0, 1, 0, 0,  0,  0, 0, 0,  0,  0);
        vecs[16] = mkv(46, 0, 0, 0, 0,  0,  0, 0, 0,  0,  0);

        // Power-on reset, then an asynchronous reset dropped into a running transform.
        #2;
        check("por outputs", 32'(observe()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-rst rd_en", 32'(rd_en), 32'd1);
        #2 rst = 1'b1;
        #1 check("async rst outputs", 32'(observe()), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle after rst", 32'(observe()), 32'd0);

        // Full transform with start pulsed for one cycle.
        run_capture(1'b0);
        check_run("run1");

        // Reset during stage 2 RUN, then a fresh full transform.
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid-run stage", 32'(stage), 32'd2);
        check("mid-run rd_addr0", 32'(rd_addr0), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rst in stage2 outputs", 32'(observe()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_capture(1'b0);
        check_run("after_rst");

        // start held high: one done, restart only after returning to IDLE.
        run_capture(1'b1);
        begin
            int n_done;
            n_done = 0;
            for (int c = 0; c <= 46; c++) if (cap[c].done) n_done++;
            check("held-start done pulses", n_done, 1);
            check("held-start cyc45", 32'(cap[45]), 32'(vecs[15].exp));
            check("held-start idle cyc46", 32'(cap[46]), 32'd0);
            check("held-start restart cyc47", 32'(cap[47]), 32'(vecs[1].exp));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
